// File: rtl/ifq_pkg.sv
// Shared constants and the queued line entry type for the instruction fetch queue.
package ifq_pkg;
  localparam int W_INSN      = 32;
  localparam int W_LINE      = 128;
  localparam int N_WORDS     = W_LINE / W_INSN;
  localparam int DEPTH       = 4;
  localparam int W_PTR       = $clog2(DEPTH);
  localparam int W_OFF       = $clog2(N_WORDS);

  typedef struct packed {
    logic [W_INSN-1:0] tag;
    logic [W_LINE-1:0] line;
  } line_entry_t;
endpackage

// File: rtl/ifq_line_fifo.sv
// Line queue for the fetch unit: DEPTH entries of {tag, line} with wrapping
// read/write pointers and an occupancy count; flush empties it in one cycle.
module ifq_line_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = ifq_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  line_entry_t                push_entry,
  input  logic                       pop,
  output line_entry_t                head_entry,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int W_P = $clog2(DEPTH);

  line_entry_t          mem_r [DEPTH];
  logic [W_P-1:0]       wr_ptr_r;
  logic [W_P-1:0]       rd_ptr_r;
  logic [W_P:0]         count_r;

  // Line storage; contents are only meaningful below count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= {W_P{1'b0}};
      rd_ptr_r <= {W_P{1'b0}};
      count_r  <= {(W_P+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + W_P'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + W_P'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (W_P+1)'(1);
        2'b01:   count_r <= count_r - (W_P+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry and occupancy out
  always_comb begin
    head_entry = mem_r[rd_ptr_r];
    count      = count_r;
  end
endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: fetches whole lines from a same-cycle icache and hands out
// one instruction per dispatch. Define IFQ_BYPASS_EN to expose a line arriving into an empty queue immediately.
module ifq
  import ifq_pkg::*;
#(
  parameter int W_INSN = ifq_pkg::W_INSN,
  parameter int W_LINE = ifq_pkg::W_LINE,
  parameter int DEPTH  = ifq_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  output logic [W_INSN-1:0] ifq_pc_in,
  output logic              ifq_rd_en,
  output logic              ifq_abort,
  input  logic [W_LINE-1:0] ifq_dout,
  input  logic              ifq_dout_valid,
  input  logic [W_INSN-1:0] jmp_branch_address,
  input  logic              jmp_branch_valid,
  input  logic              dispatch_en,
  output logic [W_INSN-1:0] ifq_insn,
  output logic [W_INSN-1:0] ifq_pc,
  output logic              ifq_empty
);
  localparam int N_W  = W_LINE / W_INSN;
  localparam int W_O  = $clog2(N_W);
  localparam int W_IB = $clog2(W_INSN / 8);
  localparam int W_LB = W_O + W_IB;
  localparam int W_P  = $clog2(DEPTH);

  localparam logic [W_P:0]      EMPTY_CNT = {(W_P+1){1'b0}};
  localparam logic [W_P:0]      FULL_CNT  = (W_P+1)'(DEPTH);
  localparam logic [W_O-1:0]    LAST_OFF  = W_O'(N_W - 1);
  localparam logic [W_INSN-1:0] LINE_STEP = W_INSN'(W_LINE / 8);
  localparam logic [W_INSN-1:0] LINE_MASK = ~(LINE_STEP - W_INSN'(1));

  logic [W_INSN-1:0] fetch_pc_r;
  logic [W_O-1:0]    word_off_r;
  logic [W_P:0]      count_s;
  line_entry_t       head_s;
  line_entry_t       push_entry_s;
  logic [W_LINE-1:0] sel_line_s;
  logic [W_INSN-1:0] sel_tag_s;
  logic              full_s;
  logic              accept_s;
  logic              bypass_s;
  logic              empty_s;
  logic              consume_s;
  logic              last_s;
  logic              push_s;
  logic              pop_s;

  ifq_line_fifo #(
    .DEPTH (DEPTH)
  ) u_line_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (jmp_branch_valid),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head_entry (head_s),
    .count      (count_s)
  );

  // Fetch request, head word selection and queue push/pop decisions
  always_comb begin
    full_s    = (count_s == FULL_CNT);
    ifq_rd_en = ~full_s & ~jmp_branch_valid & ~reset;
    ifq_abort = jmp_branch_valid & ~reset;
    ifq_pc_in = fetch_pc_r;
    accept_s  = ifq_rd_en & ifq_dout_valid;
`ifdef IFQ_BYPASS_EN
    bypass_s  = accept_s & (count_s == EMPTY_CNT);
`else
    bypass_s  = 1'b0;
`endif
    empty_s   = reset | ((count_s == EMPTY_CNT) & ~bypass_s);

    if (bypass_s) begin
      sel_line_s = ifq_dout;
      sel_tag_s  = fetch_pc_r;
    end else begin
      sel_line_s = head_s.line;
      sel_tag_s  = head_s.tag;
    end

    if (empty_s) begin
      ifq_insn = {W_INSN{1'b0}};
      ifq_pc   = {W_INSN{1'b0}};
    end else begin
      ifq_insn = sel_line_s[word_off_r*W_INSN +: W_INSN];
      ifq_pc   = sel_tag_s | W_INSN'({word_off_r, {W_IB{1'b0}}});
    end
    ifq_empty = empty_s;

    consume_s = dispatch_en & ~empty_s & ~jmp_branch_valid;
    last_s    = (word_off_r == LAST_OFF);
    pop_s     = consume_s & last_s & ~bypass_s;
    // A bypassed line fully consumed on arrival never needs a slot
    push_s    = accept_s & ~(bypass_s & consume_s & last_s);

    push_entry_s.tag  = fetch_pc_r;
    push_entry_s.line = ifq_dout;
  end

  // Fetch address and word offset into the head line; redirect wins over everything but reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r <= {W_INSN{1'b0}};
      word_off_r <= {W_O{1'b0}};
    end else if (jmp_branch_valid) begin
      fetch_pc_r <= jmp_branch_address & LINE_MASK;
      word_off_r <= jmp_branch_address[W_LB-1:W_IB];
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + LINE_STEP;
      end
      if (consume_s) begin
        word_off_r <= word_off_r + W_O'(1);
      end
    end
  end
endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: directed scenarios plus a randomized run checked
// against an address-stream reference model (icache word at byte address A is A>>2).
module tb_ifq;
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  ifq_pc_in;
  logic         ifq_rd_en;
  logic         ifq_abort;
  logic [127:0] ifq_dout;
  logic         ifq_dout_valid;
  logic [31:0]  jmp_branch_address;
  logic         jmp_branch_valid;
  logic         dispatch_en;
  logic [31:0]  ifq_insn;
  logic [31:0]  ifq_pc;
  logic         ifq_empty;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: next PC to hand out, and the address of the next line to fetch
  logic [31:0] m_pc;
  logic [31:0] m_front;
  logic [31:0] m_lines;
  logic        e_rd_en, e_write, e_avail, e_abort;
  logic [31:0] e_pc, e_insn;

  ifq dut (
    .clk                (clk),
    .reset              (reset),
    .ifq_pc_in          (ifq_pc_in),
    .ifq_rd_en          (ifq_rd_en),
    .ifq_abort          (ifq_abort),
    .ifq_dout           (ifq_dout),
    .ifq_dout_valid     (ifq_dout_valid),
    .jmp_branch_address (jmp_branch_address),
    .jmp_branch_valid   (jmp_branch_valid),
    .dispatch_en        (dispatch_en),
    .ifq_insn           (ifq_insn),
    .ifq_pc             (ifq_pc),
    .ifq_empty          (ifq_empty)
  );

  always #5 clk = ~clk;

  // icache model; data on invalid cycles is scrambled so a stray write shows up
  always_comb begin
    ifq_dout = 128'h0;
    for (int k = 0; k < 4; k++)
      ifq_dout[32*k +: 32] = ((ifq_pc_in + 32'(4*k)) >> 2) ^ (ifq_dout_valid ? 32'h0 : 32'hDEADBEEF);
  end

  // Expected outputs: lines held = whole lines between the line of m_pc and the fetch frontier
  always_comb begin
    m_lines = (m_front - {m_pc[31:4], 4'h0}) >> 4;
    e_rd_en = (m_lines != 32'd4) && !jmp_branch_valid && !reset;
    e_write = e_rd_en && ifq_dout_valid;
`ifdef IFQ_BYPASS_EN
    e_avail = !reset && ((m_lines != 32'd0) || e_write);
`else
    e_avail = !reset && (m_lines != 32'd0);
`endif
    e_abort = jmp_branch_valid && !reset;
    e_pc    = e_avail ? m_pc : 32'h0;
    e_insn  = e_avail ? (m_pc >> 2) : 32'h0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_pc    <= 32'h0;
      m_front <= 32'h0;
    end else if (jmp_branch_valid) begin
      m_pc    <= jmp_branch_address;
      m_front <= {jmp_branch_address[31:4], 4'h0};
    end else begin
      if (e_write) m_front <= m_front + 32'd16;
      if (dispatch_en && e_avail) m_pc <= m_pc + 32'd4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; jmp_branch_valid = 1'b0; dispatch_en = 1'b0; ifq_dout_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dispatch_en = 1'b1; ifq_dout_valid = 1'b1; jmp_branch_valid = 1'b0;
    jmp_branch_address = 32'h0000_0100;
    @(negedge clk);
    n_checks++; if (ifq_rd_en !== 1'b0) $display("FAIL reset_rd_en got %0b want 0", ifq_rd_en); else n_pass++;
    n_checks++; if (ifq_empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", ifq_empty); else n_pass++;
    n_checks++; if (ifq_insn !== 32'h0) $display("FAIL reset_insn got %h want 0", ifq_insn); else n_pass++;
    n_checks++; if (ifq_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", ifq_pc); else n_pass++;
    tick();
    jmp_branch_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (ifq_abort !== 1'b0) $display("FAIL reset_abort got %0b want 0", ifq_abort); else n_pass++;
    tick();
    reset = 1'b0; jmp_branch_valid = 1'b0; dispatch_en = 1'b0; ifq_dout_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ifq_pc_in !== 32'h0) $display("FAIL reset_pc_in got %h want 0", ifq_pc_in); else n_pass++;
    n_checks++; if (ifq_rd_en !== 1'b1) $display("FAIL reset_rel_rd_en got %0b want 1", ifq_rd_en); else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    bit seen = 1'b0;
    int gaps = 0;
    logic [31:0] first_pc = 32'hFFFF_FFFF;
    do_reset();
    dispatch_en = 1'b1; ifq_dout_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ifq_empty && !seen) begin seen = 1'b1; first_pc = ifq_pc; end
      else if (seen && ifq_empty) gaps++;
      n_checks++;
      if ({ifq_empty, ifq_pc, ifq_insn} !== {!e_avail, e_pc, e_insn})
        $display("FAIL stream_c%0d got e=%0b pc=%h i=%h want e=%0b pc=%h i=%h", i, ifq_empty, ifq_pc, ifq_insn, !e_avail, e_pc, e_insn);
      else n_pass++;
      tick();
    end
    n_checks++; if (first_pc !== 32'h0) $display("FAIL stream_first_pc got %h want 0", first_pc); else n_pass++;
    n_checks++; if (gaps !== 0) $display("FAIL stream_gaps got %0d want 0", gaps); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    dispatch_en = 1'b0; ifq_dout_valid = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    n_checks++; if (ifq_rd_en !== 1'b0) $display("FAIL stall_rd_en got %0b want 0", ifq_rd_en); else n_pass++;
    n_checks++; if (ifq_pc_in !== 32'h40) $display("FAIL stall_pc_in got %h want 40", ifq_pc_in); else n_pass++;
    n_checks++; if (ifq_insn !== 32'h0 || ifq_empty !== 1'b0) $display("FAIL stall_head got insn=%h e=%0b want 0/0", ifq_insn, ifq_empty); else n_pass++;
  endtask

  // Runs straight after test_stall, so the queue is full
  task automatic test_redirect();
    bit found = 1'b0;
    jmp_branch_valid = 1'b1; jmp_branch_address = 32'h0000_010C; dispatch_en = 1'b1;
    @(negedge clk);
    n_checks++; if (ifq_abort !== 1'b1) $display("FAIL redir_abort got %0b want 1", ifq_abort); else n_pass++;
    n_checks++; if (ifq_rd_en !== 1'b0) $display("FAIL redir_rd_en got %0b want 0", ifq_rd_en); else n_pass++;
    tick();
    jmp_branch_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ifq_abort !== 1'b0) $display("FAIL redir_abort_once got %0b want 0", ifq_abort); else n_pass++;
    n_checks++; if (ifq_pc_in !== 32'h100) $display("FAIL redir_fetch got %h want 100", ifq_pc_in); else n_pass++;
    for (int i = 0; i < 6 && !found; i++) begin
      if (!ifq_empty) found = 1'b1;
      else begin tick(); @(negedge clk); end
    end
    n_checks++; if (found !== 1'b1) $display("FAIL redir_timeout got empty want data"); else n_pass++;
    n_checks++; if (ifq_pc !== 32'h10C || ifq_insn !== 32'h43) $display("FAIL redir_first got pc=%h i=%h want 10c/43", ifq_pc, ifq_insn); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (ifq_pc !== 32'h110 || ifq_insn !== 32'h44) $display("FAIL redir_second got pc=%h i=%h want 110/44", ifq_pc, ifq_insn); else n_pass++;
  endtask

  task automatic test_full_retire();
    do_reset();
    dispatch_en = 1'b0; ifq_dout_valid = 1'b1;
    repeat (6) tick();
    dispatch_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (ifq_rd_en !== 1'b0) $display("FAIL fullret_rd_en got %0b want 0", ifq_rd_en); else n_pass++;
    n_checks++; if (ifq_pc !== 32'hC || ifq_insn !== 32'h3) $display("FAIL fullret_head got pc=%h i=%h want c/3", ifq_pc, ifq_insn); else n_pass++;
    tick();
    dispatch_en = 1'b0;
    @(negedge clk);
    n_checks++; if (ifq_rd_en !== 1'b1 || ifq_pc_in !== 32'h40) $display("FAIL fullret_refill got rd=%0b a=%h want 1/40", ifq_rd_en, ifq_pc_in); else n_pass++;
    n_checks++; if (ifq_pc !== 32'h10) $display("FAIL fullret_next got %h want 10", ifq_pc); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (ifq_rd_en !== 1'b0 || ifq_pc_in !== 32'h50) $display("FAIL fullret_written got rd=%0b a=%h want 0/50", ifq_rd_en, ifq_pc_in); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dispatch_en = 1'b0; ifq_dout_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (ifq_pc_in !== 32'h30) $display("FAIL rstmid_setup got %h want 30", ifq_pc_in); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (ifq_empty !== 1'b1 || ifq_insn !== 32'h0) $display("FAIL rstmid_during got e=%0b i=%h want 1/0", ifq_empty, ifq_insn); else n_pass++;
    tick();
    reset = 1'b0; ifq_dout_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ifq_empty !== 1'b1) $display("FAIL rstmid_empty got %0b want 1", ifq_empty); else n_pass++;
    n_checks++; if (ifq_pc_in !== 32'h0 || ifq_rd_en !== 1'b1) $display("FAIL rstmid_refetch got a=%h rd=%0b want 0/1", ifq_pc_in, ifq_rd_en); else n_pass++;
    tick();
    ifq_dout_valid = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (ifq_empty !== 1'b0 || ifq_pc !== 32'h0 || ifq_insn !== 32'h0) $display("FAIL rstmid_first got e=%0b pc=%h want 0/0", ifq_empty, ifq_pc); else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    jmp_branch_valid = 1'b1; jmp_branch_address = 32'h0000_0020;
    tick();
    jmp_branch_valid = 1'b0; ifq_dout_valid = 1'b1; dispatch_en = 1'b1;
    @(negedge clk);
`ifdef IFQ_BYPASS_EN
    n_checks++; if (ifq_empty !== 1'b0 || ifq_insn !== 32'h8 || ifq_pc !== 32'h20) $display("FAIL bypass_same got e=%0b i=%h want 0/8", ifq_empty, ifq_insn); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (ifq_insn !== 32'h9 || ifq_pc !== 32'h24) $display("FAIL bypass_next got i=%h pc=%h want 9/24", ifq_insn, ifq_pc); else n_pass++;
`else
    n_checks++; if (ifq_empty !== 1'b1 || ifq_insn !== 32'h0) $display("FAIL nobypass_same got e=%0b i=%h want 1/0", ifq_empty, ifq_insn); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (ifq_insn !== 32'h8 || ifq_pc !== 32'h20) $display("FAIL nobypass_next got i=%h pc=%h want 8/20", ifq_insn, ifq_pc); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      jmp_branch_valid = (r < 5);
      reset = (r >= 98);
      jmp_branch_address = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3C)) : ($urandom & 32'h0000_FFFC);
      ifq_dout_valid = ($urandom_range(0, 9) < 7);
      dispatch_en = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      n_checks++; if (ifq_rd_en !== e_rd_en) $display("FAIL rnd_rd_en c%0d got %0b want %0b", i, ifq_rd_en, e_rd_en); else n_pass++;
      n_checks++; if (ifq_pc_in !== m_front) $display("FAIL rnd_pc_in c%0d got %h want %h", i, ifq_pc_in, m_front); else n_pass++;
      n_checks++; if (ifq_abort !== e_abort) $display("FAIL rnd_abort c%0d got %0b want %0b", i, ifq_abort, e_abort); else n_pass++;
      n_checks++; if (ifq_empty !== !e_avail) $display("FAIL rnd_empty c%0d got %0b want %0b", i, ifq_empty, !e_avail); else n_pass++;
      n_checks++; if (ifq_pc !== e_pc) $display("FAIL rnd_pc c%0d got %h want %h", i, ifq_pc, e_pc); else n_pass++;
      n_checks++; if (ifq_insn !== e_insn) $display("FAIL rnd_insn c%0d got %h want %h", i, ifq_insn, e_insn); else n_pass++;
      tick();
    end
    reset = 1'b0; jmp_branch_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; jmp_branch_valid = 1'b0; jmp_branch_address = 32'h0;
    dispatch_en = 1'b0; ifq_dout_valid = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_full_retire();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
